// File: rtl/gcd_pkg.sv
// Shared types and default widths for the GCD scheduler slice.
//   sched_state_t : scheduler FSM states (IDLE, START, WAIT, RESP)
//   GCD_W         : default operand/result width
//   GCD_NREQ      : default number of requesters
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

  localparam int GCD_W    = 8;
  localparam int GCD_NREQ = 4;

endpackage

// File: rtl/gcd_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
// Scans req starting at ptr and wrapping modulo NREQ; the first set bit wins.
//   req     in  NREQ  request vector
//   ptr     in  PW    index with highest priority this cycle
//   grant   out NREQ  one-hot grant (all zero when no request)
//   win     out PW    encoded winner index (0 when no request)
//   any_req out 1     at least one request present
// The pointer register itself is owned by the instantiating block.
module rr_arbiter
  import gcd_pkg::*;
#(
  parameter int NREQ = GCD_NREQ,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   win,
  output logic            any_req
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  always_comb begin
    grant   = '0;
    win     = '0;
    any_req = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      // ptr + k folded back into 0..NREQ-1 without a divider
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) begin
        sum = sum - (PW+1)'(NREQ);
      end
      idx = sum[PW-1:0];
      if (!any_req && req[idx]) begin
        any_req    = 1'b1;
        win        = idx;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gcd_sched.sv
// Round-robin scheduler sharing one subtractive GCD engine among NREQ clients.
// Accepts one operand pair at a time (valid/ready), starts the engine with a
// one-cycle pulse, waits for done and returns the result to the granted
// requester as a one-cycle response pulse. Zero operands bypass the engine.
//
// Optional build macro GCD_SCHED_TIMEOUT_EN: adds a WAIT-state watchdog that
// aborts the engine after TIMEOUT cycles and responds with rsp_err=1, data 0.
// Without it rsp_err and eng_abort are constant 0 and WAIT waits forever.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/x/y       per-requester request, operands packed at [i*W +: W]
//   req_ready           one-hot accept (IDLE only)
//   rsp_valid/data/err  one-hot response pulse with result and abort flag
//   eng_start/x/y       engine start pulse and latched operands
//   eng_done/result     engine completion, sampled only in WAIT
//   eng_abort           one-cycle pulse forcing the engine back to idle
module gcd_sched
  import gcd_pkg::*;
#(
  parameter int NREQ    = GCD_NREQ,
  parameter int W       = GCD_W,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_data,
  output logic              rsp_err,
  output logic              eng_start,
  output logic [W-1:0]      eng_x,
  output logic [W-1:0]      eng_y,
  input  logic              eng_done,
  input  logic [W-1:0]      eng_result,
  output logic              eng_abort
);

  localparam int PW = $clog2(NREQ);

  sched_state_t  state, state_nxt;
  logic [PW-1:0] ptr, gid;
  logic [W-1:0]  x_q, y_q, res_q;
  logic          err_q;

  logic [NREQ-1:0] grant;
  logic [PW-1:0]   win;
  logic            any_req;
  logic [W-1:0]    sel_x, sel_y;
  logic            bypass;
  logic            tmo;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .grant   (grant),
    .win     (win),
    .any_req (any_req)
  );

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == PW'(i)) begin
        sel_x = req_x[i*W +: W];
        sel_y = req_y[i*W +: W];
      end
    end
  end

  // gcd(0,b)=b and gcd(0,0)=0 both reduce to a plain OR
  assign bypass = (sel_x == '0) || (sel_y == '0);

`ifdef GCD_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0] wait_cnt;

  // Cleared in START so the first WAIT cycle sees 0
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == START) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  assign tmo = (state == WAIT) && (wait_cnt == CW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = bypass ? RESP : START;
      START:   state_nxt = WAIT;
      WAIT:    if (eng_done || tmo) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    rsp_data  = '0;
    rsp_err   = 1'b0;
    eng_start = 1'b0;
    eng_abort = 1'b0;
    case (state)
      IDLE:  req_ready = grant;
      START: eng_start = 1'b1;
      // done has priority over a coincident timeout
      WAIT:  eng_abort = tmo && !eng_done;
      RESP: begin
        rsp_valid[gid] = 1'b1;
        rsp_data       = res_q;
        rsp_err        = err_q;
      end
      default: ;
    endcase
  end

  assign eng_x = x_q;
  assign eng_y = y_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      gid   <= '0;
      x_q   <= '0;
      y_q   <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            x_q   <= sel_x;
            y_q   <= sel_y;
            gid   <= win;
            ptr   <= (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
            res_q <= sel_x | sel_y;
            err_q <= 1'b0;
          end
        end
        WAIT: begin
          if (eng_done) begin
            res_q <= eng_result;
            err_q <= 1'b0;
          end else if (tmo) begin
            res_q <= '0;
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_sched.sv
// Testbench for gcd_sched: directed scenarios plus randomized traffic, checked
// every cycle against a transaction-level latency/arbitration model.
module tb_gcd_sched;

  localparam int NREQ    = 4;
  localparam int W       = 8;
  localparam int TIMEOUT = 16;
`ifdef GCD_SCHED_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_x, req_y;
  logic [NREQ-1:0]   req_ready, rsp_valid;
  logic [W-1:0]      rsp_data;
  logic              rsp_err, eng_start, eng_abort;
  logic [W-1:0]      eng_x, eng_y;
  logic              eng_done;
  logic [W-1:0]      eng_result;

  always #5 clk = ~clk;

  gcd_sched #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y),
    .eng_done(eng_done), .eng_result(eng_result), .eng_abort(eng_abort)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  function automatic int gcd_f(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- engine stand-in ----------------
  int e_delay_cfg = -1;   // -1: random delay per start
  bit spur_en     = 1'b0; // occasional done pulses while the engine is idle
  bit spur_all    = 1'b0; // done pulse on every idle cycle
  bit e_busy      = 1'b0;
  int e_rem       = 0;

  initial begin
    eng_done   = 1'b0;
    eng_result = '0;
    forever begin
      @(negedge clk);
      if (rst || eng_abort) begin
        e_busy = 1'b0;
      end else if (eng_start) begin
        e_busy = 1'b1;
        if (e_delay_cfg >= 0) e_rem = e_delay_cfg;
        else if (TMO_EN && $urandom_range(0, 7) == 0) e_rem = 9999;
        else e_rem = int'($urandom_range(0, TMO_EN ? 20 : 12));
      end
      @(posedge clk);
      #1;
      if (e_busy) begin
        if (e_rem == 0) begin
          eng_done   = 1'b1;
          eng_result = W'(gcd_f(int'(eng_x), int'(eng_y)));
          e_busy     = 1'b0;
        end else begin
          eng_done = 1'b0;
          e_rem--;
        end
      end else if (spur_all || (spur_en && $urandom_range(0, 3) == 0)) begin
        eng_done   = 1'b1;
        eng_result = W'($urandom);
      end else begin
        eng_done = 1'b0;
      end
    end
  end

  // ---------------- transaction model ----------------
  bit          m_init = 1'b0, m_busy = 1'b0, m_byp = 1'b0, m_err = 1'b0, prev_rst = 1'b0;
  int          m_acc = 0, m_resp_at = -1, m_gid = 0, m_ptr = 0, m_exp = 0;
  logic [W-1:0] m_ex = '0, m_ey = '0;

  // observed events, used by the directed literal checks
  int n_rsp = 0, n_start = 0, n_abort = 0;
  int last_rsp_cyc = 0, last_start_cyc = 0, last_acc_cyc = 0, last_abort_cyc = 0;
  logic [NREQ-1:0] last_rsp_vec = '0;
  logic [W-1:0]    last_rsp_data = '0;
  logic            last_rsp_err = 1'b0;
  int grants[$];

  task automatic check_cycle();
    logic [NREQ-1:0] e_ready, e_rv;
    logic [W-1:0]    e_data, xv, yv;
    logic            e_err, e_start, e_abort, chk_data, acc, resp_now;
    int              win, i;
    e_ready = '0; e_rv = '0; e_data = '0; e_err = 1'b0;
    e_start = 1'b0; e_abort = 1'b0; chk_data = prev_rst;
    acc = 1'b0; resp_now = 1'b0; win = -1; xv = '0; yv = '0;
    if (m_init) begin
      if (!m_busy) begin
        for (int k = 0; k < NREQ; k++) begin
          i = (m_ptr + k) % NREQ;
          if (win < 0 && req_valid[i]) win = i;
        end
        if (win >= 0) begin
          e_ready[win] = 1'b1;
          acc = !rst;
          xv = req_x[win*W +: W];
          yv = req_y[win*W +: W];
        end
      end else if (cyc == m_resp_at) begin
        e_rv[m_gid] = 1'b1;
        e_data = W'(m_exp);
        e_err = m_err;
        chk_data = 1'b1;
        resp_now = 1'b1;
      end else if (!m_byp && cyc == m_acc + 1) begin
        e_start = 1'b1;
      end else if (!m_byp) begin
        if (eng_done) begin
          m_resp_at = cyc + 1;
        end else if (TMO_EN && cyc == m_acc + 2 + TIMEOUT - 1) begin
          e_abort = 1'b1;
          m_resp_at = cyc + 1;
          m_err = 1'b1;
          m_exp = 0;
        end
      end
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      chk("eng_start", 32'(eng_start), 32'(e_start));
      chk("eng_abort", 32'(eng_abort), 32'(e_abort));
      chk("eng_x", 32'(eng_x), 32'(m_ex));
      chk("eng_y", 32'(eng_y), 32'(m_ey));
      if (chk_data) begin
        chk("rsp_data", 32'(rsp_data), 32'(e_data));
        chk("rsp_err", 32'(rsp_err), 32'(e_err));
      end
    end
    if (resp_now) m_busy = 1'b0;
    if (acc) begin
      m_busy = 1'b1; m_acc = cyc; m_gid = win; m_ptr = (win + 1) % NREQ;
      m_ex = xv; m_ey = yv; m_byp = (xv == 0) || (yv == 0);
      m_exp = gcd_f(int'(xv), int'(yv)); m_err = 1'b0;
      m_resp_at = m_byp ? cyc + 1 : -1;
    end
    if (req_ready != '0) begin
      for (int k = 0; k < NREQ; k++) if (req_ready[k]) grants.push_back(k);
      last_acc_cyc = cyc;
    end
    if (rsp_valid != '0) begin
      n_rsp++; last_rsp_cyc = cyc; last_rsp_vec = rsp_valid;
      last_rsp_data = rsp_data; last_rsp_err = rsp_err;
    end
    if (eng_start) begin n_start++; last_start_cyc = cyc; end
    if (eng_abort) begin n_abort++; last_abort_cyc = cyc; end
    if (rst) begin
      m_init = 1'b1; m_busy = 1'b0; m_ptr = 0; m_ex = '0; m_ey = '0;
    end
    prev_rst = rst;
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_n(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic send(input int r, input int x, input int y);
    req_valid = '0;
    req_valid[r] = 1'b1;
    req_x[r*W +: W] = W'(x);
    req_y[r*W +: W] = W'(y);
    tick();
    req_valid = '0;
  endtask

  task automatic wait_rsp(input string nm, input int bound);
    int n0;
    n0 = n_rsp;
    for (int k = 0; k < bound && n_rsp == n0; k++) tick();
    chk({nm, "_rsp_seen"}, 32'(n_rsp != n0), 32'd1);
  endtask

  initial begin
    int s0, r0;
    rst = 1'b1; req_valid = '0; req_x = '0; req_y = '0;
    idle_n(2);
    rst = 1'b0;
    idle_n(2);

    // single request through the engine
    e_delay_cfg = 5;
    send(0, 48, 18);
    wait_rsp("single", 40);
    chk("single_start_lat", 32'(last_start_cyc - last_acc_cyc), 32'd1);
    chk("single_rsp_lat", 32'(last_rsp_cyc - last_acc_cyc), 32'd8);
    chk("single_data", 32'(last_rsp_data), 32'd6);
    chk("single_vec", 32'(last_rsp_vec), 32'h1);
    idle_n(2);

    // fairness with all requesters held, pointer back at 0 after reset
    rst = 1'b1; tick(); rst = 1'b0;
    e_delay_cfg = 0;
    grants.delete();
    req_x = {8'd100, 8'd9, 8'd35, 8'd12};
    req_y = {8'd75, 8'd6, 8'd21, 8'd18};
    req_valid = '1;
    for (int k = 0; k < 60 && grants.size() < 5; k++) tick();
    req_valid = '0;
    chk("fair_count", 32'(grants.size()), 32'd5);
    if (grants.size() >= 5) begin
      chk("fair_g0", 32'(grants[0]), 32'd0);
      chk("fair_g1", 32'(grants[1]), 32'd1);
      chk("fair_g2", 32'(grants[2]), 32'd2);
      chk("fair_g3", 32'(grants[3]), 32'd3);
      chk("fair_g4", 32'(grants[4]), 32'd0);
    end
    idle_n(10);

    // zero-operand bypass
    s0 = n_start;
    send(1, 0, 35);
    wait_rsp("byp1", 5);
    chk("byp1_data", 32'(last_rsp_data), 32'd35);
    chk("byp1_lat", 32'(last_rsp_cyc - last_acc_cyc), 32'd1);
    send(2, 0, 0);
    wait_rsp("byp2", 5);
    chk("byp2_data", 32'(last_rsp_data), 32'd0);
    send(3, 77, 0);
    wait_rsp("byp3", 5);
    chk("byp3_data", 32'(last_rsp_data), 32'd77);
    chk("byp_no_start", 32'(n_start), 32'(s0));
    idle_n(2);

    // reset while waiting on the engine
    e_delay_cfg = 30;
    send(2, 40, 24);
    idle_n(5);
    r0 = n_rsp;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_eng_x", 32'(eng_x), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    idle_n(35);
    chk("rst_dropped", 32'(n_rsp), 32'(r0));
    e_delay_cfg = 0;
    req_x = {8'd20, 8'd30, 8'd40, 8'd50};
    req_y = {8'd5, 8'd6, 8'd7, 8'd8};
    req_valid = '1;
    tick();
    req_valid = '0;
    chk("rst_first_grant", 32'(grants[$]), 32'd0);
    idle_n(6);

    // spurious done in IDLE/START/RESP must be ignored
    spur_all = 1'b1;
    e_delay_cfg = 3;
    send(1, 12, 8);
    wait_rsp("spur", 20);
    chk("spur_data", 32'(last_rsp_data), 32'd4);
    spur_all = 1'b0;
    idle_n(3);

`ifdef GCD_SCHED_TIMEOUT_EN
    // engine never finishes
    s0 = n_abort;
    e_delay_cfg = 9999;
    send(0, 50, 20);
    wait_rsp("tmo", 60);
    chk("tmo_err", 32'(last_rsp_err), 32'd1);
    chk("tmo_data", 32'(last_rsp_data), 32'd0);
    chk("tmo_lat", 32'(last_rsp_cyc - last_acc_cyc), 32'(TIMEOUT + 2));
    chk("tmo_abort_cnt", 32'(n_abort), 32'(s0 + 1));
    chk("tmo_abort_lat", 32'(last_abort_cyc - last_acc_cyc), 32'(TIMEOUT + 1));
    idle_n(3);
    // done coincides with the timeout cycle
    e_delay_cfg = TIMEOUT - 1;
    send(3, 50, 20);
    wait_rsp("tie", 60);
    chk("tie_err", 32'(last_rsp_err), 32'd0);
    chk("tie_data", 32'(last_rsp_data), 32'd10);
    chk("tie_abort_cnt", 32'(n_abort), 32'(s0 + 1));
    idle_n(3);
`endif

    // randomized traffic
    e_delay_cfg = -1;
    spur_en = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        req_valid = '0;
      end else begin
        rst = 1'b0;
        for (int r = 0; r < NREQ; r++) begin
          req_valid[r] = ($urandom_range(0, 2) == 0);
          req_x[r*W +: W] = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 255));
          req_y[r*W +: W] = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 255));
        end
      end
      tick();
    end
    rst = 1'b0;
    req_valid = '0;
    idle_n(60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gcd_sched.md
Name: gcd_sched

Overview:
Round-robin scheduler that shares one subtractive GCD engine (controller plus x/y datapath) among NREQ requesters. It accepts one operand pair at a time through a valid/ready handshake and drives the engine through a start/done handshake. It returns the result to the granted requester as a one-cycle response pulse. It sits between client blocks and the existing GCD engine, and is the only block that drives the engine's start input.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 8, operand/result width in bits
TIMEOUT, 1024, max WAIT cycles before abort (used only with the optional feature)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  NREQ  per-requester request valid
req_x  in  NREQ*W  packed operand x, requester i at bits [i*W +: W]
req_y  in  NREQ*W  packed operand y, same packing
req_ready  out  NREQ  one-hot accept, at most one bit high per cycle
rsp_valid  out  NREQ  one-hot one-cycle response pulse
rsp_data  out  W  GCD result, valid while any rsp_valid bit is high
rsp_err  out  1  response carries an abort (timeout), qualified by rsp_valid
eng_start  out  1  one-cycle start pulse to engine
eng_x  out  W  latched operand x to engine
eng_y  out  W  latched operand y to engine
eng_done  in  1  engine finished (pulse or level; sampled only in WAIT)
eng_result  in  W  engine result, valid when eng_done=1
eng_abort  out  1  one-cycle pulse forcing engine back to idle

Behaviour:
- Reset (rst=1 at a clk edge, any state, including mid-operation):
  - state=IDLE, rr pointer=0, grant id=0.
  - All outputs 0: req_ready, rsp_valid, rsp_data, rsp_err, eng_start, eng_x, eng_y, eng_abort.
  - An in-flight request is dropped with no response.
- States: IDLE, START, WAIT, RESP.
- IDLE:
  - Winner is the first i with req_valid[i]=1, scanning from the pointer upward and wrapping modulo NREQ.
  - req_ready[win]=1 combinationally in the same cycle; the transfer completes that cycle.
  - On accept: latch x, y and grant id; pointer <= (win+1) mod NREQ.
  - If latched x==0 or y==0: rsp_data latch <= x|y (gcd(0,b)=b, gcd(0,0)=0), next state RESP. The engine is not started.
  - Otherwise next state START.
  - req_ready stays 0 in every state except IDLE.
- START: eng_start=1 for exactly one cycle; next state WAIT.
- WAIT:
  - When eng_done=1: latch eng_result; next state RESP.
  - eng_done is ignored in IDLE, START and RESP.
- RESP: rsp_valid[grant]=1 for one cycle, with rsp_data=latched result; next state IDLE. There is no backpressure on responses.
- Latency, counted from the accept cycle as cycle 0:
  - Engine path: eng_start at cycle 1; if eng_done is first seen at cycle k, rsp_valid is at cycle k+1.
  - Bypass path: rsp_valid at cycle 1.
- Throughput: the earliest next accept is the cycle after RESP.
- A requester may hold req_valid high through its own response; it re-arbitrates normally.
- eng_x and eng_y hold their latched values from the accept until the next accept.
- Width: operands are unsigned W bits; the scheduler performs no arithmetic on data beyond the zero test and the OR.

Optional Feature:
Macro GCD_SCHED_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT-1 with eng_done=0: eng_abort=1 for one cycle, next state RESP, rsp_data=0, rsp_err=1.
  - If eng_done=1 and timeout occur in the same cycle, eng_done wins (normal result, rsp_err=0).
- Not defined: no counter is built, rsp_err is tied 0, eng_abort is tied 0, and WAIT waits indefinitely.

Decomposition:
- Package gcd_pkg:
  - sched_state_t enum {IDLE, START, WAIT, RESP} as logic [1:0].
  - Default-width constants GCD_W=8 and GCD_NREQ=4.
- Sub-module rr_arbiter (NREQ parameter):
  - Inputs: req vector and pointer.
  - Outputs: one-hot grant, encoded winner index, any_req.
  - Purely combinational; the pointer register lives in gcd_sched.

Test Plan:
- Single request: req 0, x=48, y=18, engine model done after 5 cycles with result 6 -> req_ready[0] at cycle 0, eng_start at cycle 1, rsp_valid[0] with rsp_data=6 exactly one cycle after done.
- Fairness: all 4 req_valid held high, pointer 0 -> grant order 0,1,2,3,0 with one rsp_valid per grant, never two req_ready bits high together.
- Zero bypass: x=0, y=35 -> rsp_data=35 at cycle 1, eng_start never asserted; x=0, y=0 -> rsp_data=0.
- Reset mid-op: rst asserted during WAIT -> all outputs 0 next cycle, no rsp_valid for the dropped request, next request granted starting from requester 0.
- Spurious done: eng_done pulsed in IDLE and START -> ignored; a result arrives only after the WAIT-state done.
- Timeout (macro defined, TIMEOUT=16, engine never finishes) -> eng_abort pulse, rsp_valid with rsp_err=1 and rsp_data=0; done and timeout in the same cycle -> rsp_err=0 with the engine result.
